laser_fire_control: RTL and testbench
=====================================

# laser_fire_control

Upstream feeder for the shot projectile stage in the Arkanoid datapath. Turns the raw fire button into single-cycle `shot` requests, enforces ammo count, cooldown, and the laser power-up gate, and presents the muzzle position (`shot_x`, `shot_y`) derived from the paddle. The downstream shot stage latches position on `shot` while its `active` is low and reports `active` back here as `shot_active`.

## Interface
- `AMMO_MAX`, 8: shots granted per reload (1..15).
- `COOLDOWN`, 16: minimum clock cycles from a shot until the next one can be armed (1..255).
- `PADDLE_W`, 64: paddle width in pixels; the muzzle is at the paddle centre.
- `clock`  in  1  game clock; the same clock as the shot stage.
- `reset`  in  1  synchronous, active-high.
- `fire_btn`  in  1  raw asynchronous button, high = pressed.
- `laser_enable`  in  1  laser power-up active.
- `reload`  in  1  single-cycle pulse; sets ammo to `AMMO_MAX`.
- `paddle_x`  in  10  paddle left edge.
- `paddle_y`  in  10  paddle top edge.
- `shot_active`  in  1  shot in flight, from the shot stage.
- `shot`  out  1  single-cycle fire request.
- `shot_x`  out  10  muzzle x, valid while `shot`=1.
- `shot_y`  out  10  muzzle y, valid while `shot`=1.
- `ammo`  out  4  remaining shots.
- `ready`  out  1  high in ARMED.

## Operation
- **Button input:** 2-flop synchronizer, then a rising-edge detector producing `press`.
  - `press` is consumed only in ARMED; presses in any other state are dropped, with no queueing.
  - Holding the button does not autofire.
- **FSM states:** DISABLED, ARMED, FIRE, COOLDOWN, EMPTY.
  - **DISABLED:** go to ARMED if `laser_enable` and `ammo`≠0; go to EMPTY if `laser_enable` and `ammo`=0.
  - **ARMED:** go to FIRE on `press` && !`shot_active`.
  - **FIRE:** lasts exactly one cycle.
    - `shot`=1.
    - `shot_x` = `paddle_x` + `PADDLE_W`/2 and `shot_y` = `paddle_y` − 1, both registered on entry.
    - `ammo` decrements.
    - The cooldown counter loads `COOLDOWN`−1. Then go to COOLDOWN.
  - **COOLDOWN:** the counter decrements each cycle. When the counter is 0 and `shot_active`=0, go to ARMED if `ammo`≠0, otherwise EMPTY.
  - **EMPTY:** go to ARMED on `reload`.
- `laser_enable`=0 in any state forces DISABLED at the next edge. `shot` is never asserted in DISABLED. `ammo` is retained.
- **Reload:**
  - `reload` in any state sets `ammo`=`AMMO_MAX`.
  - `reload` coincident with FIRE gives `ammo`=`AMMO_MAX`−1.
- **Arithmetic:**
  - `shot_x`/`shot_y` are 10-bit and wrap modulo 1024. The caller guarantees `paddle_x` + `PADDLE_W`/2 ≤ 1023 and `paddle_y` ≥ 1.
  - `ammo` never underflows; FIRE is unreachable at 0.

## Timing
- **Reset values:** state DISABLED, `shot`=0, `shot_x`=0, `shot_y`=0, `ammo`=0, `ready`=0, cooldown counter=0, synchronizer flops=0.
- **Latency:** `fire_btn` is first sampled high at edge N. In ARMED with `shot_active`=0, `press` is valid after edge N+1 and `shot`=1 after edge N+2, for one cycle.
- `shot`, `shot_x`, `shot_y`, `ammo`, `ready` are all registered.
- **Shot spacing:** minimum spacing between `shot` pulses is `COOLDOWN`+1 cycles. Spacing is extended while `shot_active` remains high.
- **Reset mid-operation:** reset during FIRE or COOLDOWN returns to DISABLED with ammo 0. A shot already in flight is unaffected here.

## Structure
- **Shared definitions file:** FSM state encoding (3-bit), default `AMMO_MAX`, `COOLDOWN`, `PADDLE_W`, and the playfield constant `TOP`.
- **Sub-module `btn_sync_edge`:** 2-flop synchronizer plus rising-edge pulse, reusable for other buttons.
- The FSM, counters and output registers live in this module.

## Test plan
- **Basic fire:** reset, `reload`, `laser_enable`=1, `paddle_x`=100, `paddle_y`=400, press held 5 cycles → one `shot` pulse 3 edges after press, `shot_x`=132, `shot_y`=399, `ammo` 8→7.
- **Cooldown gating:** press every 2 cycles, `shot_active`=0 → `shot` pulses spaced exactly 17 cycles apart; intermediate presses dropped.
- **In-flight block:** `shot_active` held high 40 cycles after a shot → no `shot` until the cycle after `shot_active` falls plus the ARMED press; `ready`=0 throughout.
- **Ammo exhaustion:** 8 spaced presses → 8 shots, `ammo`=0, state EMPTY, 9th press ignored. `reload` → `ammo`=8, `ready`=1 next cycle.
- **Reload coincident with FIRE:** `ammo`=3, `reload` pulse on the FIRE cycle → `ammo`=7.
- **Disable and reset:** drop `laser_enable` during COOLDOWN → DISABLED, `ammo` retained, presses ignored. Assert `reset` → all outputs 0.

Source files
------------

// File: rtl/laser_fire_control_pkg.sv
// Shared definitions for the laser fire controller: state encoding, default
// parameters and playfield geometry.
package laser_fire_control_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED = 3'd0,
    ST_ARMED    = 3'd1,
    ST_FIRE     = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_EMPTY    = 3'd4
  } fire_state_t;

  localparam int AMMO_MAX_DEFAULT = 8;
  localparam int COOLDOWN_DEFAULT = 16;
  localparam int PADDLE_W_DEFAULT = 64;

  // First visible row of the playfield; shots leaving above it are retired downstream.
  localparam logic [9:0] TOP = 10'd16;

  function automatic logic [9:0] muzzle_x(input logic [9:0] paddle_left, input int paddle_w);
    return paddle_left + 10'(paddle_w / 2);
  endfunction

  function automatic logic [9:0] muzzle_y(input logic [9:0] paddle_top);
    return paddle_top - 10'd1;
  endfunction

endpackage

// File: rtl/laser_fire_control_btn_sync_edge.sv
// Two-flop synchronizer for an asynchronous button followed by a
// rising-edge detector that emits a one-cycle press pulse.
module btn_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  logic sync1;
  logic sync2;
  logic prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Pulse only on the synchronized 0->1 transition, so a held button never repeats.
  assign press = sync2 & ~prev;

endmodule

// File: rtl/laser_fire_control.sv
// Fire control for the paddle laser: turns button presses into single-cycle
// shot requests gated by ammo, cooldown, the power-up and shots in flight.
module laser_fire_control
  import laser_fire_control_pkg::*;
#(
  parameter int AMMO_MAX = AMMO_MAX_DEFAULT,
  parameter int COOLDOWN = COOLDOWN_DEFAULT,
  parameter int PADDLE_W = PADDLE_W_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       fire_btn,
  input  logic       laser_enable,
  input  logic       reload,
  input  logic [9:0] paddle_x,
  input  logic [9:0] paddle_y,
  input  logic       shot_active,
  output logic       shot,
  output logic [9:0] shot_x,
  output logic [9:0] shot_y,
  output logic [3:0] ammo,
  output logic       ready
);

  localparam logic [3:0] AMMO_FULL        = 4'(AMMO_MAX);
  localparam logic [3:0] AMMO_FIRE_RELOAD = 4'(AMMO_MAX - 1);
  localparam logic [7:0] COOL_LOAD        = 8'(COOLDOWN - 1);

  fire_state_t state;
  fire_state_t state_next;
  logic [7:0]  cool_cnt;
  logic [7:0]  cool_next;
  logic [3:0]  ammo_next;
  logic        press;
  logic        entering_fire;

  btn_sync_edge u_fire_btn (
    .clock (clock),
    .reset (reset),
    .btn   (fire_btn),
    .press (press)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_DISABLED;
      cool_cnt <= 8'd0;
      ammo     <= 4'd0;
    end else begin
      state    <= state_next;
      cool_cnt <= cool_next;
      ammo     <= ammo_next;
    end
  end

  // The counter is loaded on the way into FIRE and keeps counting through
  // FIRE, so the next FIRE can follow the previous one COOLDOWN+1 cycles later.
  always_comb begin
    state_next = state;
    cool_next  = cool_cnt;
    ammo_next  = ammo;

    case (state)
      ST_DISABLED: begin
        if (laser_enable) begin
          state_next = (ammo != 4'd0) ? ST_ARMED : ST_EMPTY;
        end
      end
      ST_ARMED: begin
        if (press && !shot_active && ammo != 4'd0) begin
          state_next = ST_FIRE;
          cool_next  = COOL_LOAD;
        end
      end
      ST_FIRE: begin
        state_next = ST_COOLDOWN;
        ammo_next  = ammo - 4'd1;
        if (cool_cnt != 8'd0) begin
          cool_next = cool_cnt - 8'd1;
        end
      end
      ST_COOLDOWN: begin
        if (cool_cnt == 8'd0) begin
          if (!shot_active) begin
            state_next = (ammo != 4'd0) ? ST_ARMED : ST_EMPTY;
          end
        end else begin
          cool_next = cool_cnt - 8'd1;
        end
      end
      ST_EMPTY: begin
        if (reload) begin
          state_next = ST_ARMED;
        end
      end
      default: begin
        state_next = ST_DISABLED;
      end
    endcase

    // A reload landing on the FIRE cycle still pays for that shot.
    if (reload) begin
      ammo_next = (state == ST_FIRE) ? AMMO_FIRE_RELOAD : AMMO_FULL;
    end

    if (!laser_enable) begin
      state_next = ST_DISABLED;
    end
  end

  assign entering_fire = (state_next == ST_FIRE) && (state != ST_FIRE);

  always_ff @(posedge clock) begin
    if (reset) begin
      shot   <= 1'b0;
      ready  <= 1'b0;
      shot_x <= 10'd0;
      shot_y <= 10'd0;
    end else begin
      shot  <= entering_fire;
      ready <= (state_next == ST_ARMED);
      if (entering_fire) begin
        shot_x <= muzzle_x(paddle_x, PADDLE_W);
        shot_y <= muzzle_y(paddle_y);
      end
    end
  end

endmodule

// File: tb/tb_laser_fire_control.sv
// Directed bench for laser_fire_control with a scoreboard of expected muzzle
// positions that is drained whenever the controller issues a shot.
module tb_laser_fire_control;

  logic       clock = 1'b0;
  logic       reset;
  logic       fire_btn;
  logic       laser_enable;
  logic       reload;
  logic [9:0] paddle_x;
  logic [9:0] paddle_y;
  logic       shot_active;
  logic       shot;
  logic [9:0] shot_x;
  logic [9:0] shot_y;
  logic [3:0] ammo;
  logic       ready;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
  } shot_exp_t;

  shot_exp_t exp_q[$];
  shot_exp_t popped;
  int        shot_cycles[$];
  int        cycle_count = 0;
  int        checks = 0;
  int        errors = 0;
  int        base;

  laser_fire_control dut (
    .clock        (clock),
    .reset        (reset),
    .fire_btn     (fire_btn),
    .laser_enable (laser_enable),
    .reload       (reload),
    .paddle_x     (paddle_x),
    .paddle_y     (paddle_y),
    .shot_active  (shot_active),
    .shot         (shot),
    .shot_x       (shot_x),
    .shot_y       (shot_y),
    .ammo         (ammo),
    .ready        (ready)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check_output("wait_ready", 32'(ready), 32'd1);
  endtask

  // Holds the button for `hold` edges and checks the shot lands exactly on the third edge.
  task automatic apply_stimulus(input logic [9:0] px, input logic [9:0] py,
                                input bit expect_shot, input int hold);
    shot_exp_t e;
    paddle_x = px;
    paddle_y = py;
    if (expect_shot) begin
      e.x = px + 10'd32;
      e.y = py - 10'd1;
      exp_q.push_back(e);
    end
    fire_btn = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == hold) fire_btn = 1'b0;
      if (i == 2) check_output("shot_early", 32'(shot), 32'd0);
      if (i == 3) check_output("shot_latency", 32'(shot), 32'(expect_shot));
      if (i == 4) check_output("shot_single", 32'(shot), 32'd0);
    end
    fire_btn = 1'b0;
  endtask

  // Scoreboard consumer: every shot must match the oldest expected muzzle position.
  always @(posedge clock) begin
    cycle_count++;
    #1;
    if (shot === 1'b1) begin
      shot_cycles.push_back(cycle_count);
      if (exp_q.size() == 0) begin
        check_output("unexpected_shot", 32'd1, 32'd0);
      end else begin
        popped = exp_q.pop_front();
        check_output("shot_x", 32'(shot_x), 32'(popped.x));
        check_output("shot_y", 32'(shot_y), 32'(popped.y));
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    shot_shot_e_init: begin end
    reset        = 1'b1;
    fire_btn     = 1'b0;
    laser_enable = 1'b0;
    reload       = 1'b0;
    paddle_x     = 10'd0;
    paddle_y     = 10'd0;
    shot_active  = 1'b0;
    tick(3);
    check_output("reset_shot", 32'(shot), 32'd0);
    check_output("reset_shot_x", 32'(shot_x), 32'd0);
    check_output("reset_shot_y", 32'(shot_y), 32'd0);
    check_output("reset_ammo", 32'(ammo), 32'd0);
    check_output("reset_ready", 32'(ready), 32'd0);
    reset = 1'b0;

    $display("[TB] basic fire");
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check_output("reload_ammo", 32'(ammo), 32'd8);
    laser_enable = 1'b1;
    tick();
    check_output("armed_ready", 32'(ready), 32'd1);
    apply_stimulus(10'd100, 10'd400, 1'b1, 5);
    check_output("basic_ammo", 32'(ammo), 32'd7);
    check_output("cooldown_ready", 32'(ready), 32'd0);

    $display("[TB] cooldown gating");
    wait_ready();
    paddle_x = 10'd0;
    paddle_y = 10'd1;
    exp_q.push_back('{x: 10'd32, y: 10'd0});
    exp_q.push_back('{x: 10'd32, y: 10'd0});
    base = shot_cycles.size();
    for (int k = 1; k <= 22; k++) begin
      fire_btn = (k == 1) || (k >= 4 && k <= 18 && (k % 2) == 0);
      tick();
    end
    fire_btn = 1'b0;
    tick(4);
    check_output("gating_count", 32'(shot_cycles.size() - base), 32'd2);
    if (shot_cycles.size() >= base + 2)
      check_output("gating_spacing", 32'(shot_cycles[base + 1] - shot_cycles[base]), 32'd17);
    check_output("gating_ammo", 32'(ammo), 32'd5);

    $display("[TB] in-flight block");
    wait_ready();
    paddle_x = 10'd991;
    paddle_y = 10'd1023;
    exp_q.push_back('{x: 10'd1023, y: 10'd1022});
    fire_btn = 1'b1;
    tick();
    fire_btn = 1'b0;
    tick(2);
    check_output("inflight_shot", 32'(shot), 32'd1);
    shot_active = 1'b1;
    for (int i = 0; i < 40; i++) begin
      fire_btn = (i == 20);
      tick();
      check_output("inflight_hold", {30'd0, shot, ready}, 32'd0);
    end
    fire_btn = 1'b0;
    shot_active = 1'b0;
    tick();
    check_output("ready_after_flight", 32'(ready), 32'd1);
    apply_stimulus(10'd991, 10'd1023, 1'b1, 1);
    check_output("inflight_ammo", 32'(ammo), 32'd3);

    $display("[TB] reload coincident with fire");
    wait_ready();
    paddle_x = 10'd200;
    paddle_y = 10'd300;
    exp_q.push_back('{x: 10'd232, y: 10'd299});
    fire_btn = 1'b1;
    tick();
    fire_btn = 1'b0;
    tick(2);
    check_output("reload_fire_shot", 32'(shot), 32'd1);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check_output("reload_during_fire", 32'(ammo), 32'd7);

    $display("[TB] ammo exhaustion");
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check_output("refill_ammo", 32'(ammo), 32'd8);
    for (int i = 0; i < 8; i++) begin
      wait_ready();
      apply_stimulus(10'(i * 50), 10'(100 + i), 1'b1, 1);
    end
    tick(20);
    check_output("empty_ammo", 32'(ammo), 32'd0);
    check_output("empty_ready", 32'(ready), 32'd0);
    apply_stimulus(10'd10, 10'd10, 1'b0, 1);
    check_output("empty_ignored_ready", 32'(ready), 32'd0);
    reload = 1'b1;
    tick();
    reload = 1'b0;
    check_output("empty_reload_ammo", 32'(ammo), 32'd8);
    check_output("empty_reload_ready", 32'(ready), 32'd1);

    $display("[TB] disable and reset");
    apply_stimulus(10'd100, 10'd200, 1'b1, 1);
    laser_enable = 1'b0;
    tick();
    check_output("disabled_ready", 32'(ready), 32'd0);
    apply_stimulus(10'd100, 10'd200, 1'b0, 1);
    tick(20);
    check_output("disabled_ready_late", 32'(ready), 32'd0);
    check_output("disabled_ammo", 32'(ammo), 32'd7);
    laser_enable = 1'b1;
    tick(2);
    check_output("reenable_ready", 32'(ready), 32'd1);
    apply_stimulus(10'd300, 10'd50, 1'b1, 1);
    check_output("reenable_ammo", 32'(ammo), 32'd6);
    reset = 1'b1;
    tick();
    check_output("midop_reset_shot", 32'(shot), 32'd0);
    check_output("midop_reset_shot_x", 32'(shot_x), 32'd0);
    check_output("midop_reset_shot_y", 32'(shot_y), 32'd0);
    check_output("midop_reset_ammo", 32'(ammo), 32'd0);
    check_output("midop_reset_ready", 32'(ready), 32'd0);
    reset = 1'b0;
    tick(3);
    check_output("post_reset_ready", 32'(ready), 32'd0);

    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
